bbf_operand_queue: RTL and testbench
====================================

Name: bbf_operand_queue

Overview:
- Upstream staging stage for the double-precision float black-box adder/multiplier (BBFAdder/BBFMult).
- Buffers pairs of IEEE-754 binary64 operand bit patterns in a DEPTH-entry FIFO with valid/ready handshakes.
- Presents the head pair on registered-storage outputs that wire directly to the arithmetic block's io$in1/io$in2.
- Flags special operands (NaN/Inf) at the head, and supports a synchronous flush.

Parameters:
- DEPTH, 4, number of operand-pair entries; power of two, minimum 2.
- WIDTH, 64, operand width in bits; fixed at 64 for binary64. The special-operand flag assumes 64.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted). The name follows codebase convention despite the low polarity.
- io$flush, input, 1, synchronous clear of all entries.
- io$enq_valid, input, 1, producer offers an operand pair.
- io$enq_ready, output, 1, queue can accept a pair this cycle.
- io$enq_in1, input, WIDTH, operand 1 bits.
- io$enq_in2, input, WIDTH, operand 2 bits.
- io$deq_valid, output, 1, head pair is valid.
- io$deq_ready, input, 1, consumer takes the head pair this cycle.
- io$out_in1, output, WIDTH, head operand 1; connects to adder/multiplier io$in1.
- io$out_in2, output, WIDTH, head operand 2; connects to adder/multiplier io$in2.
- io$out_special, output, 1, head in1 or in2 has exponent field [62:52] all ones (Inf or NaN).
- io$count, output, log2(DEPTH)+1, current occupancy.

Behaviour:
- Storage: DEPTH×2×WIDTH register array, read pointer rp, write pointer wp (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter cnt.
- Reset (reset=0, asynchronous): rp=0, wp=0, cnt=0. Array contents are not reset.
- Outputs at reset: io$enq_ready=1, io$deq_valid=0, io$count=0, io$out_special=0. io$out_in1 and io$out_in2 are masked to 0 while cnt=0.
- Handshake, no bypass:
  - io$enq_ready = (cnt < DEPTH).
  - io$deq_valid = (cnt != 0).
  - enq fires when io$enq_valid && io$enq_ready. deq fires when io$deq_valid && io$deq_ready.
  - io$enq_ready does not depend on io$deq_ready. A full queue never accepts, even if a dequeue happens the same cycle.
- Latency: a pair enqueued at edge N is visible on io$out_* with io$deq_valid=1 after edge N. Minimum latency 1 cycle; no combinational enq→deq path.
- Per edge:
  - enq fire: write both operands at wp, wp++.
  - deq fire: rp++.
  - cnt: +1 on enq only, -1 on deq only, unchanged when both fire.
- Empty with enq_valid and deq_ready both high: only the enq occurs; cnt 0→1.
- Full with deq fire: cnt DEPTH→DEPTH-1. io$enq_ready rises the following cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Ordering is strictly FIFO.
- io$out_in1/io$out_in2 are combinational reads of entry rp, zero when cnt=0. They are held stable while io$deq_valid=1 and io$deq_ready=0.
- io$out_special = deq_valid && (&out_in1[62:52] || &out_in2[62:52]). The data is never modified.
- io$flush=1 at an edge: rp=wp=cnt=0. Flush overrides any enq/deq firing that cycle; the offered pair is dropped.
- Asynchronous reset mid-operation discards all entries immediately. Outputs go to reset values without waiting for a clock edge.
- Producer rule: once io$enq_valid is raised, hold it and its data until accepted. Not checked by the block.

Test Plan:
- Reset then single pair: enq in1=0x3FF0000000000000 (1.0), in2=0x4000000000000000 (2.0).
  - Next cycle: deq_valid=1, out_in1/out_in2 match, count=1, special=0.
  - deq_ready=1 for one cycle: count=0, deq_valid=0, outputs read 0.
- Fill and backpressure: enqueue 5 pairs (k, k+1) for k=1..5 with deq_ready=0.
  - Pairs 1–4 accepted; enq_ready=0 at count=4; pair 5 held.
  - Then deq_ready=1: outputs pair1..pair4 in order; pair5 accepted the cycle after the first deq.
- Wrap and simultaneous enq/deq: stream 12 pairs with enq_valid=deq_ready=1 continuously after the first.
  - count stays 1; output order matches input across two pointer wraps.
- Special flag: enqueue (0x7FF0000000000000, 1.0), (1.0, 0x7FF8000000000000), (1.0, 2.0).
  - out_special reads 1, 1, 0 as each pair reaches the head.
- Flush priority: with count=3, assert flush together with enq_valid=1 and deq_ready=1.
  - Next cycle: count=0, deq_valid=0, enq_ready=1; the offered pair is absent.
- Async reset mid-stream: with count=2, pull reset low between clock edges.
  - count=0, deq_valid=0, enq_ready=1 immediately.
  - After release, a new enq appears at the head after one edge.

Source files
------------

// File: rtl/bbf_operand_queue.sv
// ---------------------------------------------------------------------------
// bbf_operand_queue
//
// Staging FIFO for operand pairs that feed the binary64 black-box adder /
// multiplier. Pairs are written in at the tail. The head pair is read
// combinationally from register storage and drives the arithmetic block's
// in1/in2 directly. An enqueued pair cannot pass straight through to the
// outputs in the same cycle, so the minimum latency is one cycle.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous reset, active low (0 = in reset)
//   io_flush        synchronous clear of all entries; overrides enq/deq
//   io_enq_valid    producer offers a pair
//   io_enq_ready    queue has room (cnt < DEPTH); ignores io_deq_ready
//   io_enq_in1/2    operand bit patterns offered by the producer
//   io_deq_valid    head pair is valid (cnt != 0)
//   io_deq_ready    consumer takes the head pair
//   io_out_in1/2    head operands, forced to zero while empty
//   io_out_special  head in1 or in2 is Inf/NaN (exponent all ones)
//   io_count        current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module bbf_operand_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_flush,
  input  logic                   io_enq_valid,
  output logic                   io_enq_ready,
  input  logic [WIDTH-1:0]       io_enq_in1,
  input  logic [WIDTH-1:0]       io_enq_in2,
  output logic                   io_deq_valid,
  input  logic                   io_deq_ready,
  output logic [WIDTH-1:0]       io_out_in1,
  output logic [WIDTH-1:0]       io_out_in2,
  output logic                   io_out_special,
  output logic [$clog2(DEPTH):0] io_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Operand storage; contents are deliberately left unreset.
  logic [WIDTH-1:0] mem_in1 [DEPTH];
  logic [WIDTH-1:0] mem_in2 [DEPTH];

  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [CW-1:0] cnt;

  logic enq_fire;
  logic deq_fire;
  logic head_special1;
  logic head_special2;

  always_comb begin
    io_enq_ready = (cnt < FULL_CNT);
    io_deq_valid = (cnt != '0);
    enq_fire     = io_enq_valid && io_enq_ready;
    deq_fire     = io_deq_valid && io_deq_ready;
  end

  // Storage write. A flushed cycle drops the offered pair.
  always_ff @(posedge clock) begin
    if (enq_fire && !io_flush) begin
      mem_in1[wp] <= io_enq_in1;
      mem_in2[wp] <= io_enq_in2;
    end
  end

  // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (io_flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (enq_fire) begin
        wp <= wp + AW'(1);
      end
      if (deq_fire) begin
        rp <= rp + AW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head presentation, masked to zero while empty
  always_comb begin
    io_out_in1 = '0;
    io_out_in2 = '0;
    if (io_deq_valid) begin
      io_out_in1 = mem_in1[rp];
      io_out_in2 = mem_in2[rp];
    end
  end

  // Binary64 exponent field is bits [62:52]; all ones means Inf or NaN.
  always_comb begin
    head_special1  = &io_out_in1[62:52];
    head_special2  = &io_out_in2[62:52];
    io_out_special = io_deq_valid && (head_special1 || head_special2);
  end

  assign io_count = cnt;

endmodule

// File: tb/tb_bbf_operand_queue.sv
module tb_bbf_operand_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
  } pair_t;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [63:0] enq_in1;
  logic [63:0] enq_in2;
  logic        deq_valid;
  logic        deq_ready;
  logic [63:0] out_in1;
  logic [63:0] out_in2;
  logic        out_special;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  pair_t model_q[$];

  bbf_operand_queue #(.DEPTH(DEPTH), .WIDTH(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_flush       (flush),
    .io_enq_valid   (enq_valid),
    .io_enq_ready   (enq_ready),
    .io_enq_in1     (enq_in1),
    .io_enq_in2     (enq_in2),
    .io_deq_valid   (deq_valid),
    .io_deq_ready   (deq_ready),
    .io_out_in1     (out_in1),
    .io_out_in2     (out_in2),
    .io_out_special (out_special),
    .io_count       (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit is_special(logic [63:0] x);
    return ((x >> 52) & 64'h7FF) == 64'h7FF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] e1, e2;
    bit sz;
    sz = (model_q.size() != 0);
    e1 = sz ? model_q[0].a : 64'd0;
    e2 = sz ? model_q[0].b : 64'd0;
    chk({tag, ".count"},     64'(count),       64'(model_q.size()));
    chk({tag, ".deq_valid"}, 64'(deq_valid),   64'(sz));
    chk({tag, ".enq_ready"}, 64'(enq_ready),   64'(model_q.size() < DEPTH));
    chk({tag, ".out_in1"},   out_in1,          e1);
    chk({tag, ".out_in2"},   out_in2,          e2);
    chk({tag, ".special"},   64'(out_special), 64'(sz && (is_special(e1) || is_special(e2))));
  endtask

  task automatic step(input string tag, input bit v, input logic [63:0] a, input logic [63:0] b,
                      input bit dr, input bit fl, output bit accepted);
    bit ef, df;
    pair_t p;
    enq_valid = v;
    enq_in1   = a;
    enq_in2   = b;
    deq_ready = dr;
    flush     = fl;
    #1;
    check_outputs({tag, ".pre"});
    ef = v && (model_q.size() < DEPTH);
    df = dr && (model_q.size() != 0);
    accepted = ef && !fl;
    p.a = a;
    p.b = b;
    @(posedge clock);
    #1;
    if (fl) begin
      model_q.delete();
    end else begin
      if (df) void'(model_q.pop_front());
      if (ef) model_q.push_back(p);
    end
    check_outputs({tag, ".post"});
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0;
    enq_in1   = 64'd0;
    enq_in2   = 64'd0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  localparam logic [63:0] ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] TWO  = 64'h4000000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  initial begin
    bit acc;
    int k;
    pair_t pend;
    bit    pend_v;

    idle_inputs();
    reset = 1'b0;
    #3;
    check_outputs("reset");
    #4;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_outputs("post_reset");

    step("single_enq", 1'b1, ONE, TWO, 1'b0, 1'b0, acc);
    chk("single.acc", 64'(acc), 64'd1);
    chk("single.in1_const", out_in1, ONE);
    chk("single.in2_const", out_in2, TWO);
    chk("single.count_const", 64'(count), 64'd1);
    step("single_deq", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("single.empty_out", out_in1, 64'd0);
    chk("single.empty_valid", 64'(deq_valid), 64'd0);

    k = 1;
    for (int c = 0; c < 6; c++) begin
      step("fill", 1'b1, 64'(k), 64'(k + 1), 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("fill.held_at_5", 64'(k), 64'd5);
    chk("fill.full_ready", 64'(enq_ready), 64'd0);
    begin
      bit took5 = 1'b0;
      int when5 = -1;
      for (int c = 0; c < 6; c++) begin
        step("drain", !took5, 64'd5, 64'd6, 1'b1, 1'b0, acc);
        if (acc && !took5) begin
          took5 = 1'b1;
          when5 = c;
        end
      end
      chk("fill.pair5_cycle", 64'(when5), 64'd1);
    end
    while (model_q.size() != 0) step("drain_rest", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);

    step("wrap_first", 1'b1, 64'h100, 64'h200, 1'b0, 1'b0, acc);
    for (int i = 1; i < 12; i++) begin
      step("wrap", 1'b1, 64'(32'h100 + i), 64'(32'h200 + i), 1'b1, 1'b0, acc);
      chk("wrap.count_one", 64'(count), 64'd1);
    end
    step("wrap_last", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);

    step("sp_enq0", 1'b1, PINF, ONE, 1'b0, 1'b0, acc);
    step("sp_enq1", 1'b1, ONE, QNAN, 1'b0, 1'b0, acc);
    step("sp_enq2", 1'b1, ONE, TWO, 1'b0, 1'b0, acc);
    chk("special.head0", 64'(out_special), 64'd1);
    step("sp_deq0", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("special.head1", 64'(out_special), 64'd1);
    step("sp_deq1", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("special.head2", 64'(out_special), 64'd0);
    step("sp_deq2", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);

    for (int i = 0; i < 3; i++) step("fl_fill", 1'b1, 64'(i + 7), 64'(i + 9), 1'b0, 1'b0, acc);
    chk("flush.count3", 64'(count), 64'd3);
    step("flush", 1'b1, 64'hDEAD, 64'hBEEF, 1'b1, 1'b1, acc);
    chk("flush.count0", 64'(count), 64'd0);
    chk("flush.ready", 64'(enq_ready), 64'd1);
    chk("flush.valid", 64'(deq_valid), 64'd0);

    step("ar_fill0", 1'b1, 64'h11, 64'h22, 1'b0, 1'b0, acc);
    step("ar_fill1", 1'b1, 64'h33, 64'h44, 1'b0, 1'b0, acc);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_reset");
    chk("async_reset.count", 64'(count), 64'd0);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step("ar_new", 1'b1, 64'h55, 64'h66, 1'b0, 1'b0, acc);
    chk("ar_new.head", out_in1, 64'h55);
    step("ar_clear", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);

    pend_v = 1'b0;
    pend   = '0;
    for (int c = 0; c < 400; c++) begin
      bit dr, fl;
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend.a = {$urandom, $urandom};
        pend.b = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) pend.a = pend.a | PINF;
        if ($urandom_range(0, 7) == 0) pend.b = pend.b | PINF;
        pend_v = 1'b1;
      end
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 39) == 0);
      step("rand", pend_v, pend_v ? pend.a : 64'd0, pend_v ? pend.b : 64'd0, dr, fl, acc);
      if (acc || fl) pend_v = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
